reg_file_sb: RTL and testbench

- Parametrised successor to the single-cycle core's 32x32 register file.
- Keeps the 2-read/1-write architectural register array and adds:
  - configurable width and depth,
  - hardwired-zero register 0,
  - optional same-cycle write-to-read bypass,
  - a per-register busy scoreboard that lets a pipelined core detect RAW and WAW hazards.
- Sits between decode (read and issue) and writeback (write and clear).

---
 rtl/reg_file_sb.sv | 103 ++++++++++
 tb/tb_reg_file_sb.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// Parametrised 2-read/1-write register file with hardwired-zero register,
// optional write-to-read bypass and a per-register busy scoreboard.
module reg_file_sb #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int AW       = 5,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [AW-1:0]    ra1,
  input  logic [AW-1:0]    ra2,
  output logic [XLEN-1:0]  rd1,
  output logic [XLEN-1:0]  rd2,
  output logic             busy1,
  output logic             busy2,
  input  logic             we3,
  input  logic [AW-1:0]    wa3,
  input  logic [XLEN-1:0]  wd3,
  input  logic             iss_valid,
  input  logic [AW-1:0]    iss_rd,
  output logic             iss_conflict,
  output logic [NREGS-1:0] busy_vec
);

  localparam bit LP_BYP  = (BYPASS != 0);
  localparam bit LP_ZERO = (ZERO_REG != 0);

  logic [XLEN-1:0]  r_mem [NREGS];
  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_busy_next;
  logic             w_wr_zero;

  assign w_wr_zero = LP_ZERO && (wa3 == '0);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < NREGS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (we3 && !w_wr_zero) begin
      r_mem[wa3] <= wd3;
    end
  end

  // Clear first, then set: a new producer issued in the same cycle wins.
  always_comb begin
    w_busy_next = r_busy;
    if (we3) begin
      w_busy_next[wa3] = 1'b0;
    end
    if (iss_valid) begin
      w_busy_next[iss_rd] = 1'b1;
    end
    if (LP_ZERO) begin
      w_busy_next[0] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_next;
    end
  end

  assign busy_vec = r_busy;

  logic [AW-1:0]   w_ra   [2];
  logic [XLEN-1:0] w_rd   [2];
  logic            w_busy [2];

  assign w_ra[0] = ra1;
  assign w_ra[1] = ra2;
  assign rd1     = w_rd[0];
  assign rd2     = w_rd[1];
  assign busy1   = w_busy[0];
  assign busy2   = w_busy[1];

  for (genvar gi = 0; gi < 2; gi++) begin : g_rport
    logic w_is_zero;
    logic w_hit;

    assign w_is_zero = LP_ZERO && (w_ra[gi] == '0);
    assign w_hit     = LP_BYP && we3 && (wa3 == w_ra[gi]) && !w_is_zero;

    // Reset gating keeps a bypassed wd3 from leaking out while clr is held.
    always_comb begin
      w_rd[gi] = '0;
      if (!clr && !w_is_zero) begin
        w_rd[gi] = w_hit ? wd3 : r_mem[w_ra[gi]];
      end
    end

    assign w_busy[gi] = !clr && !w_is_zero && !w_hit && r_busy[w_ra[gi]];
  end

  assign iss_conflict = !clr && iss_valid && r_busy[iss_rd] &&
                        !(LP_BYP && we3 && (wa3 == iss_rd));

endmodule

// File: tb/tb_reg_file_sb.sv
// Randomized and directed check of reg_file_sb in three configurations
// against a behavioural model of the register array and scoreboard.
module tb_reg_file_sb;

  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  // Shared stimulus for the two 32x32 instances (A: bypass, B: no bypass)
  logic [4:0]  ra1, ra2, wa3, iss_rd;
  logic        we3, iss_valid;
  logic [31:0] wd3;
  logic [31:0] a_rd1, a_rd2, b_rd1, b_rd2, a_bv, b_bv;
  logic        a_busy1, a_busy2, a_conf, b_busy1, b_busy2, b_conf;

  // Instance C: 64-bit, 16 registers, no zero register
  logic [3:0]  c_ra1, c_ra2, c_wa3, c_iss_rd;
  logic        c_we3, c_iss_valid;
  logic [63:0] c_wd3, c_rd1, c_rd2;
  logic        c_busy1, c_busy2, c_conf;
  logic [15:0] c_bv;

  reg_file_sb #(.XLEN(32), .NREGS(32), .AW(5), .BYPASS(1), .ZERO_REG(1)) u_a (
    .clk(clk), .clr(clr), .ra1(ra1), .ra2(ra2), .rd1(a_rd1), .rd2(a_rd2),
    .busy1(a_busy1), .busy2(a_busy2), .we3(we3), .wa3(wa3), .wd3(wd3),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_conflict(a_conf), .busy_vec(a_bv));

  reg_file_sb #(.XLEN(32), .NREGS(32), .AW(5), .BYPASS(0), .ZERO_REG(1)) u_b (
    .clk(clk), .clr(clr), .ra1(ra1), .ra2(ra2), .rd1(b_rd1), .rd2(b_rd2),
    .busy1(b_busy1), .busy2(b_busy2), .we3(we3), .wa3(wa3), .wd3(wd3),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_conflict(b_conf), .busy_vec(b_bv));

  reg_file_sb #(.XLEN(64), .NREGS(16), .AW(4), .BYPASS(1), .ZERO_REG(0)) u_c (
    .clk(clk), .clr(clr), .ra1(c_ra1), .ra2(c_ra2), .rd1(c_rd1), .rd2(c_rd2),
    .busy1(c_busy1), .busy2(c_busy2), .we3(c_we3), .wa3(c_wa3), .wd3(c_wd3),
    .iss_valid(c_iss_valid), .iss_rd(c_iss_rd), .iss_conflict(c_conf), .busy_vec(c_bv));

  int total = 0;
  int bad   = 0;

  // Reference state: architectural contents and outstanding writers
  logic [31:0] m_mem  [32];
  bit          m_busy [32];
  logic [63:0] c_mem  [16];
  bit          c_busy [16];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin m_mem[i] = '0; m_busy[i] = 1'b0; end
    for (int i = 0; i < 16; i++) begin c_mem[i] = '0; c_busy[i] = 1'b0; end
  endtask

  // A reader sees the in-flight writeback when bypass is on.
  function automatic logic [31:0] exp_rd_ab(input logic [4:0] a, input bit byp);
    if (clr || a == 5'd0) return '0;
    if (byp && we3 && wa3 == a) return wd3;
    return m_mem[a];
  endfunction

  function automatic logic exp_busy_ab(input logic [4:0] a, input bit byp);
    if (clr || a == 5'd0) return 1'b0;
    if (byp && we3 && wa3 == a) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic logic exp_conf_ab(input bit byp);
    if (clr || !iss_valid) return 1'b0;
    if (byp && we3 && wa3 == iss_rd) return 1'b0;
    return m_busy[iss_rd];
  endfunction

  function automatic logic [63:0] exp_rd_c(input logic [3:0] a);
    if (clr) return '0;
    if (c_we3 && c_wa3 == a) return c_wd3;
    return c_mem[a];
  endfunction

  function automatic logic exp_busy_c(input logic [3:0] a);
    if (clr || (c_we3 && c_wa3 == a)) return 1'b0;
    return c_busy[a];
  endfunction

  function automatic logic [31:0] pack_ab();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_busy[i];
    return v;
  endfunction

  function automatic logic [15:0] pack_c();
    logic [15:0] v;
    for (int i = 0; i < 16; i++) v[i] = c_busy[i];
    return v;
  endfunction

  task automatic check_comb();
    check_val("a_rd1", a_rd1, exp_rd_ab(ra1, 1'b1));
    check_val("a_rd2", a_rd2, exp_rd_ab(ra2, 1'b1));
    check_val("b_rd1", b_rd1, exp_rd_ab(ra1, 1'b0));
    check_val("b_rd2", b_rd2, exp_rd_ab(ra2, 1'b0));
    check_val("a_busy1", a_busy1, exp_busy_ab(ra1, 1'b1));
    check_val("a_busy2", a_busy2, exp_busy_ab(ra2, 1'b1));
    check_val("b_busy1", b_busy1, exp_busy_ab(ra1, 1'b0));
    check_val("b_busy2", b_busy2, exp_busy_ab(ra2, 1'b0));
    check_val("a_conf", a_conf, exp_conf_ab(1'b1));
    check_val("b_conf", b_conf, exp_conf_ab(1'b0));
    check_val("c_rd1", c_rd1, exp_rd_c(c_ra1));
    check_val("c_rd2", c_rd2, exp_rd_c(c_ra2));
    check_val("c_busy1", c_busy1, exp_busy_c(c_ra1));
    check_val("c_busy2", c_busy2, exp_busy_c(c_ra2));
    check_val("c_conf", c_conf, !clr && c_iss_valid && c_busy[c_iss_rd] &&
                                !(c_we3 && c_wa3 == c_iss_rd));
  endtask

  task automatic check_state();
    check_val("a_busy_vec", a_bv, pack_ab());
    check_val("b_busy_vec", b_bv, pack_ab());
    check_val("c_busy_vec", c_bv, pack_c());
  endtask

  task automatic model_edge();
    if (clr) return;
    if (we3 && wa3 != 5'd0) m_mem[wa3] = wd3;
    if (we3) m_busy[wa3] = 1'b0;
    if (iss_valid && iss_rd != 5'd0) m_busy[iss_rd] = 1'b1;
    if (c_we3) begin c_mem[c_wa3] = c_wd3; c_busy[c_wa3] = 1'b0; end
    if (c_iss_valid) c_busy[c_iss_rd] = 1'b1;
  endtask

  task automatic set_idle();
    we3 = 0; wa3 = 0; wd3 = 0; iss_valid = 0; iss_rd = 0; ra1 = 0; ra2 = 0;
    c_we3 = 0; c_wa3 = 0; c_wd3 = 0; c_iss_valid = 0; c_iss_rd = 0; c_ra1 = 0; c_ra2 = 0;
  endtask

  // Called at a negedge with inputs applied; returns at the next negedge.
  task automatic step(input string what);
    #2 check_comb();
    @(posedge clk);
    model_edge();
    #1 check_state();
    $display("%s ra1=%0d ra2=%0d we=%b wa=%0d wd=%h iss=%b/%0d a_rd1=%h a_b1=%b a_cf=%b",
             what, ra1, ra2, we3, wa3, wd3, iss_valid, iss_rd, a_rd1, a_busy1, a_conf);
    @(negedge clk);
  endtask

  // Asynchronous reset pulse raised mid-cycle, held across one edge.
  task automatic pulse_reset();
    #1 clr = 1'b1;
    model_clear();
    #1 check_comb();
    check_state();
    @(posedge clk);
    #1 check_comb();
    check_state();
    @(negedge clk);
    clr = 1'b0;
    $display("reset pulse");
  endtask

  initial begin
    set_idle();
    model_clear();
    #1 check_comb();
    check_state();
    @(negedge clk);
    clr = 1'b0;

    // Write x5 then drop reset mid-cycle with a write still being driven
    we3 = 1; wa3 = 5; wd3 = 32'hDEADBEEF; ra1 = 5;
    step("wr_x5");
    set_idle(); ra1 = 5; we3 = 1; wa3 = 6; wd3 = 32'h1111_2222; iss_valid = 1; iss_rd = 6;
    #1 check_val("x5_before_clr", a_rd1, 32'hDEADBEEF);
    #1 clr = 1'b1;
    model_clear();
    #1 check_val("x5_async_clr", a_rd1, 32'h0);
    check_val("busy_vec_clr", a_bv, 32'h0);
    @(negedge clk);
    check_val("x5_after_clr", a_rd1, 32'h0);
    check_val("x6_dropped", a_bv, 32'h0);
    clr = 1'b0;
    set_idle();

    // Register 0 ignores writes
    we3 = 1; wa3 = 0; wd3 = 32'h12345678; ra1 = 0;
    step("wr_x0");
    set_idle();
    #1 check_val("x0_zero", a_rd1, 32'h0);
    step("rd_x0");

    // Write x7: bypass shows it before the edge, no-bypass shows old value
    we3 = 1; wa3 = 7; wd3 = 32'hA5A5A5A5; ra1 = 7; ra2 = 7;
    #1 check_val("x7_bypass", a_rd1, 32'hA5A5A5A5);
    check_val("x7_nobypass", b_rd1, 32'h0);
    step("wr_x7");
    set_idle(); ra2 = 7;
    #1 check_val("x7_after", b_rd2, 32'hA5A5A5A5);
    step("rd_x7");

    // RAW: issue x3, then write it back
    iss_valid = 1; iss_rd = 3; ra1 = 3;
    #1 check_val("iss3_not_yet", a_busy1, 1'b0);
    step("iss_x3");
    set_idle(); ra1 = 3;
    #1 check_val("x3_busy", a_busy1, 1'b1);
    check_val("x3_bv", a_bv[3], 1'b1);
    step("hold_x3");
    we3 = 1; wa3 = 3; wd3 = 32'h55;
    #1 check_val("x3_wb_busy", a_busy1, 1'b0);
    check_val("x3_wb_rd", a_rd1, 32'h55);
    check_val("x3_wb_busy_nb", b_busy1, 1'b1);
    step("wb_x3");
    check_val("x3_cleared", a_bv[3], 1'b0);
    set_idle();

    // Set and clear x9 in the same cycle
    iss_valid = 1; iss_rd = 9;
    step("iss_x9");
    we3 = 1; wa3 = 9; wd3 = 32'h9999; iss_valid = 1; iss_rd = 9;
    #1 check_val("x9_conf_byp", a_conf, 1'b0);
    check_val("x9_conf_nobyp", b_conf, 1'b1);
    step("wb_iss_x9");
    set_idle(); ra1 = 9;
    check_val("x9_still_busy", a_bv[9], 1'b1);
    #1 check_val("x9_data", b_rd1, 32'h9999);
    step("rd_x9");

    // WAW on x12
    iss_valid = 1; iss_rd = 12;
    step("iss_x12");
    #1 check_val("x12_waw", a_conf, 1'b1);
    step("iss_x12_again");
    check_val("x12_busy", a_bv[12], 1'b1);
    set_idle(); we3 = 1; wa3 = 12; wd3 = 32'hC;
    step("wb_x12");
    check_val("x12_cleared", a_bv[12], 1'b0);
    set_idle();

    // 64-bit / no zero register: x0 is a real register
    c_we3 = 1; c_wa3 = 0; c_wd3 = 64'hFFFF_FFFF_FFFF_FFFF; c_iss_valid = 1; c_iss_rd = 0; c_ra1 = 0;
    step("c_wr_x0");
    set_idle();
    #1 check_val("c_x0_data", c_rd1, 64'hFFFF_FFFF_FFFF_FFFF);
    check_val("c_x0_busy", c_busy1, 1'b1);
    check_val("c_x0_bv", c_bv[0], 1'b1);
    step("c_rd_x0");

    // Randomized run; narrow address range half the time to force collisions
    for (int n = 0; n < 10000; n++) begin
      if ($urandom_range(0, 499) == 0) begin
        set_idle();
        we3 = 1; wa3 = 5'($urandom); wd3 = $urandom;
        pulse_reset();
        set_idle();
      end else begin
        bit narrow;
        narrow = $urandom_range(0, 1) == 1;
        ra1 = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
        ra2 = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
        wa3 = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
        iss_rd = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
        we3 = 1'($urandom); iss_valid = 1'($urandom); wd3 = $urandom;
        c_ra1 = 4'($urandom_range(0, 7)); c_ra2 = 4'($urandom);
        c_wa3 = 4'($urandom_range(0, 7)); c_iss_rd = 4'($urandom_range(0, 7));
        c_we3 = 1'($urandom); c_iss_valid = 1'($urandom); c_wd3 = {$urandom, $urandom};
        step("rnd");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
